// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the pipeline register chain.
// Holds the default entry widths, the default memory-ready stage and the
// stage-entry layout (at default widths) used by the chain and its bench.
package pipe_reg_chain_pkg;

    localparam int unsigned WIDTH_DEF     = 16;
    localparam int unsigned AW_DEF        = 3;
    localparam int unsigned CW_DEF        = 10;
    localparam int unsigned DEPTH_DEF     = 4;
    localparam int unsigned MEM_READY_DEF = 2;

    // One pipeline stage entry at default widths.
    typedef struct packed {
        logic                  valid;
        logic [WIDTH_DEF-1:0]  data;
        logic [CW_DEF-1:0]     ctrl;
        logic [AW_DEF-1:0]     wadd;
        logic                  regwrite;
        logic                  memrd;
    } stage_t;

endpackage

// File: rtl/pipe_lookup.sv
// Priority address match of one source register against all chain stages.
// Macro PIPE_FORWARD_EN: when defined, the youngest matching stage forwards
// its data unless it is a memory read that is not yet ready (then hazard).
// When undefined, no forwarding: any valid regwrite match raises hazard.
// Ports:
//   valid_i, regwrite_i, memrd_i  per-stage flags (bit 0 = youngest)
//   wadd_i, data_i                per-stage write address and data
//   src_i                         source register address being looked up
//   hit_o, data_o                 forwarding hit and forwarded data
//   hazard_o                      source cannot be satisfied this cycle
module pipe_lookup
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned MEM_READY = MEM_READY_DEF
) (
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [DEPTH-1:0]            regwrite_i,
    input  logic [DEPTH-1:0]            memrd_i,
    input  logic [DEPTH-1:0][AW-1:0]    wadd_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] data_i,
    input  logic [AW-1:0]               src_i,
    output logic                        hit_o,
    output logic [WIDTH-1:0]            data_o,
    output logic                        hazard_o
);

    // Stages that currently write the looked-up register.
    logic [DEPTH-1:0] match_c;

    always_comb begin
        match_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match_c[i] = valid_i[i] & regwrite_i[i] & (wadd_i[i] == src_i);
        end
    end

`ifdef PIPE_FORWARD_EN
    // Youngest match decides; older matches are never consulted.
    always_comb begin
        logic found;
        found    = 1'b0;
        hit_o    = 1'b0;
        data_o   = '0;
        hazard_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && match_c[i]) begin
                found = 1'b1;
                if (memrd_i[i] && (i < MEM_READY)) begin
                    hazard_o = 1'b1;
                end else begin
                    hit_o  = 1'b1;
                    data_o = data_i[i];
                end
            end
        end
    end
`else
    // Without forwarding, stage data and load flags play no part.
    localparam int unsigned UNUSED_MEM_READY = MEM_READY;
    logic unused_fields_c;

    assign unused_fields_c = ^{data_i, memrd_i};
    assign hit_o           = 1'b0;
    assign data_o          = '0;
    assign hazard_o        = |match_c;
`endif

endmodule

// File: rtl/pipe_reg_chain.sv
// Stallable, flushable pipeline register chain with operand forwarding lookup.
// Macro PIPE_FORWARD_EN selects forwarding lookup (see pipe_lookup).
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   in_*                         entry entering stage 0
//   stall                        holds every stage
//   flush[DEPTH]                 per-stage invalidate (bit 0 = youngest)
//   src_a, src_b                 decode-stage source addresses
//   out_*                        entry leaving stage DEPTH-1 (zero when invalid)
//   fwd_a/b_hit, fwd_a/b_data    forwarding result per source
//   hazard                       either source must wait
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned CW        = CW_DEF,
    parameter int unsigned MEM_READY = MEM_READY_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_ctrl,
    input  logic [AW-1:0]    in_wadd,
    input  logic             in_regwrite,
    input  logic             in_memrd,
    input  logic             stall,
    input  logic [DEPTH-1:0] flush,
    input  logic [AW-1:0]    src_a,
    input  logic [AW-1:0]    src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_ctrl,
    output logic [AW-1:0]    out_wadd,
    output logic             out_regwrite,
    output logic             fwd_a_hit,
    output logic             fwd_b_hit,
    output logic [WIDTH-1:0] fwd_a_data,
    output logic [WIDTH-1:0] fwd_b_data,
    output logic             hazard
);

    if ((DEPTH < 2) || (DEPTH > 8)) begin : g_depth_check
        $error("pipe_reg_chain: DEPTH must be in 2..8");
    end

    // Stage entry at the configured widths (same layout as stage_t).
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    ctrl;
        logic [AW-1:0]    wadd;
        logic             regwrite;
        logic             memrd;
    } entry_t;

    entry_t stage_q [DEPTH];
    entry_t in_entry_c;

    always_comb begin
        in_entry_c          = '0;
        in_entry_c.valid    = in_valid;
        in_entry_c.data     = in_data;
        in_entry_c.ctrl     = in_ctrl;
        in_entry_c.wadd     = in_wadd;
        in_entry_c.regwrite = in_regwrite;
        in_entry_c.memrd    = in_memrd;
    end

    // Identical stages: hold on stall, else advance; flush kills the loaded valid.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        entry_t src_c;
        entry_t stage_d;

        if (k == 0) begin : g_head
            assign src_c = in_entry_c;
        end else begin : g_body
            assign src_c = stage_q[k-1];
        end

        always_comb begin
            stage_d = stall ? stage_q[k] : src_c;
            if (flush[k]) begin
                stage_d.valid = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_q[k] <= '0;
            end else begin
                stage_q[k] <= stage_d;
            end
        end
    end

    // Output stage; an empty stage presents all zeros.
    assign out_valid    = stage_q[DEPTH-1].valid;
    assign out_data     = out_valid ? stage_q[DEPTH-1].data : '0;
    assign out_ctrl     = out_valid ? stage_q[DEPTH-1].ctrl : '0;
    assign out_wadd     = out_valid ? stage_q[DEPTH-1].wadd : '0;
    assign out_regwrite = out_valid & stage_q[DEPTH-1].regwrite;

    // Flattened per-stage views for the lookup units.
    logic [DEPTH-1:0]            valid_vec_c;
    logic [DEPTH-1:0]            rw_vec_c;
    logic [DEPTH-1:0]            memrd_vec_c;
    logic [DEPTH-1:0][AW-1:0]    wadd_vec_c;
    logic [DEPTH-1:0][WIDTH-1:0] data_vec_c;

    always_comb begin
        valid_vec_c = '0;
        rw_vec_c    = '0;
        memrd_vec_c = '0;
        wadd_vec_c  = '0;
        data_vec_c  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_vec_c[i] = stage_q[i].valid;
            rw_vec_c[i]    = stage_q[i].regwrite;
            memrd_vec_c[i] = stage_q[i].memrd;
            wadd_vec_c[i]  = stage_q[i].wadd;
            data_vec_c[i]  = stage_q[i].data;
        end
    end

    logic hazard_a_c;
    logic hazard_b_c;

    pipe_lookup #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .AW        (AW),
        .MEM_READY (MEM_READY)
    ) u_lookup_a (
        .valid_i    (valid_vec_c),
        .regwrite_i (rw_vec_c),
        .memrd_i    (memrd_vec_c),
        .wadd_i     (wadd_vec_c),
        .data_i     (data_vec_c),
        .src_i      (src_a),
        .hit_o      (fwd_a_hit),
        .data_o     (fwd_a_data),
        .hazard_o   (hazard_a_c)
    );

    pipe_lookup #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .AW        (AW),
        .MEM_READY (MEM_READY)
    ) u_lookup_b (
        .valid_i    (valid_vec_c),
        .regwrite_i (rw_vec_c),
        .memrd_i    (memrd_vec_c),
        .wadd_i     (wadd_vec_c),
        .data_i     (data_vec_c),
        .src_i      (src_b),
        .hit_o      (fwd_b_hit),
        .data_o     (fwd_b_data),
        .hazard_o   (hazard_b_c)
    );

    assign hazard = hazard_a_c | hazard_b_c;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain at default parameters (DEPTH 4, MEM_READY 2).
// Expected lookup results depend on whether PIPE_FORWARD_EN is defined.
module tb_pipe_reg_chain;
    import pipe_reg_chain_pkg::*;

`ifdef PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic [9:0]  in_ctrl;
    logic [2:0]  in_wadd;
    logic        in_regwrite;
    logic        in_memrd;
    logic        stall;
    logic [3:0]  flush;
    logic [2:0]  src_a;
    logic [2:0]  src_b;
    logic        out_valid;
    logic [15:0] out_data;
    logic [9:0]  out_ctrl;
    logic [2:0]  out_wadd;
    logic        out_regwrite;
    logic        fwd_a_hit;
    logic        fwd_b_hit;
    logic [15:0] fwd_a_data;
    logic [15:0] fwd_b_data;
    logic        hazard;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    stage_t      sb[$];

    pipe_reg_chain dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_wadd      (in_wadd),
        .in_regwrite  (in_regwrite),
        .in_memrd     (in_memrd),
        .stall        (stall),
        .flush        (flush),
        .src_a        (src_a),
        .src_b        (src_b),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_wadd     (out_wadd),
        .out_regwrite (out_regwrite),
        .fwd_a_hit    (fwd_a_hit),
        .fwd_b_hit    (fwd_b_hit),
        .fwd_a_data   (fwd_a_data),
        .fwd_b_data   (fwd_b_data),
        .hazard       (hazard)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present one entry for one clock; queue it if it must reach the output.
    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] wa,
                         input logic rw, input logic mr, input logic exp_out);
        stage_t e;
        in_valid    = v;
        in_data     = d;
        in_ctrl     = d[9:0] ^ 10'h155;
        in_wadd     = wa;
        in_regwrite = rw;
        in_memrd    = mr;
        if (v && exp_out) begin
            e          = '0;
            e.valid    = 1'b1;
            e.data     = d;
            e.ctrl     = d[9:0] ^ 10'h155;
            e.wadd     = wa;
            e.regwrite = rw;
            e.memrd    = mr;
            sb.push_back(e);
        end
        step();
    endtask

    // Invalid slot carrying a tempting address that must never match.
    task automatic bubble();
        drive(1'b0, 16'hEEEE, 3'd3, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'(|{out_valid, out_data, out_ctrl, out_wadd, out_regwrite,
                          fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data, hazard}), 32'd0);
    endtask

    // Monitor: an output entry transfers when it is valid and not stalled.
    initial begin
        stage_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && out_valid && !stall) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data 0x%0h, expected no entry", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data",     32'(out_data),     32'(e.data));
                    check("out_ctrl",     32'(out_ctrl),     32'(e.ctrl));
                    check("out_wadd",     32'(out_wadd),     32'(e.wadd));
                    check("out_regwrite", 32'(out_regwrite), 32'(e.regwrite));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_wadd = '0;
        in_regwrite = 1'b0; in_memrd = 1'b0; stall = 1'b0; flush = '0;
        src_a = 3'd0; src_b = 3'd0;
        step();
        #1 check_all_zero("reset_outputs");
        step();
        reset = 1'b0;
        #1 check_all_zero("after_reset_outputs");

        // Stream 0x0001..0x0008: first output exactly 4 clocks after issue.
        for (int i = 1; i <= 8; i++) begin
            check("lat_valid", 32'(out_valid), (i >= 5) ? 32'd1 : 32'd0);
            if (i >= 5) check("lat_data", 32'(out_data), 32'(i - 4));
            drive(1'b1, 16'(i), 3'(i), 1'b1, 1'b0, 1'b1);
        end
        repeat (4) bubble();

        // Stall three cycles with 0x0012 at the output.
        for (int i = 1; i <= 5; i++) drive(1'b1, 16'(8'h10 + i), 3'd1, 1'b0, 1'b0, 1'b1);
        stall = 1'b1; in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("stall_hold", 32'(out_data), 32'h0012);
            step();
        end
        check("stall_hold_end", 32'(out_data), 32'h0012);
        stall = 1'b0;
        repeat (5) bubble();

        // Stage3 wadd3=0xBB, stage2 wadd1=0x0C, stage1 wadd3=0xAA, stage0 bubble.
        drive(1'b1, 16'h00BB, 3'd3, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 16'h000C, 3'd1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 16'h00AA, 3'd3, 1'b1, 1'b0, 1'b1);
        bubble();
        stall = 1'b1; in_valid = 1'b0; src_a = 3'd3; src_b = 3'd6;
        #1;
        check("youngest_a_hit",  32'(fwd_a_hit),  FWD ? 32'd1 : 32'd0);
        check("youngest_a_data", 32'(fwd_a_data), FWD ? 32'h00AA : 32'd0);
        check("youngest_hazard", 32'(hazard),     FWD ? 32'd0 : 32'd1);
        src_b = 3'd1;
        #1;
        check("b_hit_stage2",  32'(fwd_b_hit),  FWD ? 32'd1 : 32'd0);
        check("b_data_stage2", 32'(fwd_b_data), FWD ? 32'h000C : 32'd0);
        step();
        stall = 1'b0;
        repeat (4) bubble();

        // Load at wadd5 walks from stage1 (not ready) to stage3.
        src_a = 3'd7; src_b = 3'd5;
        drive(1'b1, 16'h0055, 3'd5, 1'b1, 1'b1, 1'b1);
        bubble();
        #1;
        check("load_s1_hazard", 32'(hazard),     32'd1);
        check("load_s1_hit",    32'(fwd_b_hit),  32'd0);
        check("load_s1_data",   32'(fwd_b_data), 32'd0);
        bubble();
        #1;
        check("load_s2_hazard", 32'(hazard),    FWD ? 32'd0 : 32'd1);
        check("load_s2_hit",    32'(fwd_b_hit), FWD ? 32'd1 : 32'd0);
        bubble();
        #1;
        check("load_s3_hazard", 32'(hazard),     FWD ? 32'd0 : 32'd1);
        check("load_s3_hit",    32'(fwd_b_hit),  FWD ? 32'd1 : 32'd0);
        check("load_s3_data",   32'(fwd_b_data), FWD ? 32'h0055 : 32'd0);
        repeat (2) bubble();

        // Flush stages 1 and 2 while stalled; only stage0 entry survives.
        src_a = 3'd0; src_b = 3'd0;
        drive(1'b1, 16'h0061, 3'd2, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0062, 3'd4, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0063, 3'd6, 1'b1, 1'b0, 1'b1);
        stall = 1'b1; in_valid = 1'b0; flush = 4'b0110;
        step();
        flush = 4'b0000; src_a = 3'd2; src_b = 3'd4;
        #1;
        check("flush_hazard", 32'(hazard),    32'd0);
        check("flush_a_hit",  32'(fwd_a_hit), 32'd0);
        check("flush_b_hit",  32'(fwd_b_hit), 32'd0);
        src_a = 3'd6;
        #1;
        check("flush_keep_hit",    32'(fwd_a_hit), FWD ? 32'd1 : 32'd0);
        check("flush_keep_hazard", 32'(hazard),    FWD ? 32'd0 : 32'd1);
        step();
        stall = 1'b0;
        repeat (4) bubble();

        // flush[0] discards the entry arriving in the same clock.
        flush = 4'b0001;
        drive(1'b1, 16'h0071, 3'd1, 1'b1, 1'b0, 1'b0);
        flush = 4'b0000; src_a = 3'd1; src_b = 3'd7;
        #1;
        check("flush0_hazard", 32'(hazard),    32'd0);
        check("flush0_hit",    32'(fwd_a_hit), 32'd0);
        repeat (4) bubble();

        // Full chain with address 0 at the output, then reset mid-stall/flush.
        src_a = 3'd0; src_b = 3'd7;
        for (int i = 0; i < 4; i++) drive(1'b1, 16'(8'h81 + i), 3'(i), 1'b1, 1'b0, 1'b0);
        stall = 1'b1; in_valid = 1'b0;
        #1;
        check("full_out_data", 32'(out_data),   32'h0081);
        check("zero_reg_hit",  32'(fwd_a_hit),  FWD ? 32'd1 : 32'd0);
        check("zero_reg_data", 32'(fwd_a_data), FWD ? 32'h0081 : 32'd0);
        check("zero_reg_haz",  32'(hazard),     FWD ? 32'd0 : 32'd1);
        flush = 4'b1010;
        #1 reset = 1'b1;
        #1 check_all_zero("async_reset_outputs");
        step();
        #1 check_all_zero("reset_over_stall_flush");
        flush = 4'b0000; stall = 1'b0;
        step();
        reset = 1'b0;
        step();
        #1 check_all_zero("post_reset_idle");

        repeat (6) bubble();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
